obstacle_scroller: RTL and testbench
====================================

Name: obstacle_scroller

Overview:
- Parametrised horizontal scroller for N obstacle columns (pipe plus coin pair) in the Flappy-VGA play field; next generation of the fixed five-pipe X store.
- Runs in the single pixel-clock domain, gated by a one-cycle `speed_tick` enable instead of a second clock.
- Adds a programmable step size, pause, respawn that preserves spacing, and a pass pulse for scoring.
- Exposes edges in scope order, which the obstacle logic and the Y lookup consume directly.

Parameters:
- NUM_OBJ, 5, number of obstacle slots (2..8); IDX_W = clog2(NUM_OBJ).
- XW, 10, coordinate width in bits.
- PIPE_W, 61, pipe width in pixels.
- COIN_W, 19, coin width in pixels.
- INTERVAL, 142, right-edge spacing between adjacent slots.
- BIRD_X, 230, bird column; the scope advances past this.
- INIT_SCOPE, 2, first slot whose initial right edge is ≥ BIRD_X.
- Legality: NUM_OBJ*INTERVAL ≥ 640+PIPE_W, and all values fit in XW bits.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-low reset.
- speed_tick  in  1  one-cycle scroll enable.
- step  in  3  pixels moved per tick (0..7).
- start  in  1  leave IDLE.
- stop  in  1  collision; freeze the field.
- pause  in  1  level; hold motion.
- ack  in  1  leave STOP.
- q_idle, q_run, q_pause, q_stop  out  1 each  one-hot state.
- scope_idx  out  IDX_W  slot currently in scope.
- pipe_l, pipe_r  out  NUM_OBJ*XW  packed edges; lane k holds slot (scope_idx+k) mod NUM_OBJ.
- coin_l, coin_r  out  NUM_OBJ*XW  packed coin edges, same lane order.
- pass_pulse  out  1  in-scope pipe cleared the bird.
- respawn_pulse  out  1  some slot wrapped this cycle.
- respawn_idx  out  IDX_W  slot that wrapped.

Behaviour:
- Storage: one XW-bit right edge R[i] per slot.
  - pipe_r = R; pipe_l = R−PIPE_W, clamped to 0 when R < PIPE_W.
  - coin_r = R; coin_l = R−COIN_W, clamped to 0.
- Reset (reset=0) and IDLE entry load initial values:
  - R[i] = PIPE_W + i*INTERVAL; scope_idx = INIT_SCOPE; state = IDLE.
  - All pulses = 0; respawn_idx = 0.
- States and transitions:
  - IDLE: hold initial values; start → RUN.
  - RUN: stop → STOP; else pause → PAUSE.
  - PAUSE: stop → STOP; pause=0 → RUN.
  - STOP: ack → IDLE.
  - stop has priority over pause and over ticks.
- Motion happens only in RUN, with speed_tick=1 and stop=0, all slots in the same cycle:
  - If R[i] > step: R[i] ← R[i]−step.
  - Else (wrap): R[i] ← R[i]−step+NUM_OBJ*INTERVAL. Spacing is exactly preserved; never saturate.
  - step=0: no motion, no pulses.
- Scope advance, evaluated on the pre-update registers in a moving tick:
  - Condition: R[scope_idx] < BIRD_X.
  - Action: scope_idx ← scope_idx+1, wrapping NUM_OBJ−1 → 0.
  - pass_pulse = 1 for the following cycle.
  - At most one advance per tick.
- Respawn pulse:
  - respawn_pulse = 1 for the cycle after a wrap; respawn_idx = the wrapped slot.
  - Only one slot can wrap per tick, because spacing ≥ 8.
- Latency: registered outputs update 1 cycle after the tick. Packed lanes are combinational from R and scope_idx.
- Boundary cases:
  - A tick while in PAUSE, STOP or IDLE is ignored.
  - A tick in the same cycle as stop does not move the field.
  - Reset mid-run restores initial values immediately.
  - Pulses never assert outside RUN.

Test Plan:
- Reset, then start, then one tick with step=1 → R = {60,202,344,486,628}; scope_idx=2; lane0 pipe_r=344, pipe_l=283.
- After 116 ticks with step=1 (R[2]=229) → the next tick gives scope_idx=3 and a one-cycle pass_pulse; lane0 becomes slot 3.
- Slot 0 from R=61: 60 ticks give R=1; the next tick wraps to 710 with respawn_pulse=1, respawn_idx=0. During the approach pipe_l stays clamped at 0.
- step=7 with R[0]=5 → R[0]=708; spacing to slot 4 (R=… +142 mod 710) is kept.
- In RUN, assert pause for 10 ticks → R unchanged. Assert stop together with a tick → STOP, no move; ack → IDLE with initial values.
- Pull reset low mid-run with scope_idx=4 → immediate IDLE, R = initial values, scope_idx=2, pulses 0.

Source files
------------

// File: rtl/obstacle_scroller.sv
// obstacle_scroller: horizontal scroller for NUM_OBJ obstacle columns (pipe + coin).
// Each slot keeps one right edge R. In RUN, every speed_tick moves all slots left
// by `step` pixels. A slot that would leave the field wraps by NUM_OBJ*INTERVAL,
// so the spacing between slots never changes. The scope pointer follows the
// first slot whose right edge has not yet cleared the bird column.
//
// Ports:
//   clk, reset          pixel clock, async active-low reset
//   speed_tick, step    one-cycle scroll enable, pixels per tick
//   start/stop/pause/ack  game control (stop = collision)
//   q_idle..q_stop      one-hot state
//   scope_idx           slot currently in scope
//   pipe_l/r, coin_l/r  packed edges, lane k = slot (scope_idx+k) mod NUM_OBJ
//   pass_pulse          in-scope pipe cleared the bird (cycle after the tick)
//   respawn_pulse/idx   a slot wrapped (cycle after the tick), and which slot

// Per-slot right-edge register with wrap-around subtract.
module obstacle_scroller_slot #(
  parameter int            XW     = 10,
  parameter logic [XW-1:0] INIT_R = '0,
  parameter logic [XW-1:0] SPAN   = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_init,
  input  logic          move,
  input  logic [2:0]    step,
  output logic [XW-1:0] r,
  output logic          wrap
);
  logic [XW-1:0] r_q, r_d, step_x;

  assign step_x = XW'(step);
  // R never reaches 0 (it stays in 1..SPAN), so R <= step means the edge leaves.
  assign wrap   = move && (r_q <= step_x);
  assign r      = r_q;

  always_comb begin
    r_d = r_q;
    if (load_init)  r_d = INIT_R;
    else if (move)  r_d = wrap ? (r_q - step_x + SPAN) : (r_q - step_x);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_q <= INIT_R;
    else        r_q <= r_d;
  end
endmodule

module obstacle_scroller #(
  parameter int NUM_OBJ    = 5,
  parameter int XW         = 10,
  parameter int PIPE_W     = 61,
  parameter int COIN_W     = 19,
  parameter int INTERVAL   = 142,
  parameter int BIRD_X     = 230,
  parameter int INIT_SCOPE = 2,
  localparam int IDX_W     = $clog2(NUM_OBJ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  speed_tick,
  input  logic [2:0]            step,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
  input  logic                  ack,
  output logic                  q_idle,
  output logic                  q_run,
  output logic                  q_pause,
  output logic                  q_stop,
  output logic [IDX_W-1:0]      scope_idx,
  output logic [NUM_OBJ*XW-1:0] pipe_l,
  output logic [NUM_OBJ*XW-1:0] pipe_r,
  output logic [NUM_OBJ*XW-1:0] coin_l,
  output logic [NUM_OBJ*XW-1:0] coin_r,
  output logic                  pass_pulse,
  output logic                  respawn_pulse,
  output logic [IDX_W-1:0]      respawn_idx
);
  localparam int SPAN = NUM_OBJ * INTERVAL;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_STOP} state_e;

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         scope_q, scope_d, ridx_q, ridx_d;
  logic                     pass_q, pass_d, resp_q, resp_d;
  logic [NUM_OBJ-1:0][XW-1:0] r_all;
  logic [NUM_OBJ-1:0]       wrap;
  logic                     load_init, moving;
  logic [XW-1:0]            r_scope;

  // FSM next state; stop outranks pause.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (stop) state_d = S_STOP; else if (pause) state_d = S_PAUSE;
      S_PAUSE: if (stop) state_d = S_STOP; else if (!pause) state_d = S_RUN;
      S_STOP:  if (ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Initial values are loaded on the same edge that enters IDLE, and held there.
  assign load_init = (state_q == S_IDLE) || ((state_q == S_STOP) && ack);
  // Pause also blocks the tick that leaves RUN, so pulses only show up in RUN.
  assign moving = (state_q == S_RUN) && speed_tick && !stop && !pause && (step != 3'd0);

  for (genvar i = 0; i < NUM_OBJ; i++) begin : g_slot
    obstacle_scroller_slot #(
      .XW    (XW),
      .INIT_R(XW'(PIPE_W + i * INTERVAL)),
      .SPAN  (XW'(SPAN))
    ) u_slot (
      .clk      (clk),
      .reset    (reset),
      .load_init(load_init),
      .move     (moving),
      .step     (step),
      .r        (r_all[i]),
      .wrap     (wrap[i])
    );
  end

  always_comb begin
    r_scope = '0;
    for (int i = 0; i < NUM_OBJ; i++)
      if (scope_q == IDX_W'(i)) r_scope = r_all[i];
  end

  // Scope and pulses are judged on the pre-move edges.
  always_comb begin
    scope_d = scope_q;
    pass_d  = 1'b0;
    resp_d  = |wrap;
    ridx_d  = ridx_q;
    for (int i = 0; i < NUM_OBJ; i++)
      if (wrap[i]) ridx_d = IDX_W'(i);
    if (load_init) begin
      scope_d = IDX_W'(INIT_SCOPE);
      ridx_d  = '0;
      resp_d  = 1'b0;
    end else if (moving && (r_scope < XW'(BIRD_X))) begin
      pass_d  = 1'b1;
      scope_d = (scope_q == IDX_W'(NUM_OBJ - 1)) ? '0 : scope_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      scope_q <= IDX_W'(INIT_SCOPE);
      pass_q  <= 1'b0;
      resp_q  <= 1'b0;
      ridx_q  <= '0;
    end else begin
      state_q <= state_d;
      scope_q <= scope_d;
      pass_q  <= pass_d;
      resp_q  <= resp_d;
      ridx_q  <= ridx_d;
    end
  end

  // Lane k shows slot (scope+k) mod NUM_OBJ; left edges clamp at 0.
  for (genvar k = 0; k < NUM_OBJ; k++) begin : g_lane
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] sel;
    logic [XW-1:0]    rk;
    assign sum = {1'b0, scope_q} + (IDX_W+1)'(k);
    assign sel = (sum >= (IDX_W+1)'(NUM_OBJ)) ? IDX_W'(sum - (IDX_W+1)'(NUM_OBJ))
                                                : sum[IDX_W-1:0];
    assign rk  = r_all[sel];
    assign pipe_r[k*XW +: XW] = rk;
    assign coin_r[k*XW +: XW] = rk;
    assign pipe_l[k*XW +: XW] = (rk >= XW'(PIPE_W)) ? rk - XW'(PIPE_W) : '0;
    assign coin_l[k*XW +: XW] = (rk >= XW'(COIN_W)) ? rk - XW'(COIN_W) : '0;
  end

  assign q_idle        = (state_q == S_IDLE);
  assign q_run         = (state_q == S_RUN);
  assign q_pause       = (state_q == S_PAUSE);
  assign q_stop        = (state_q == S_STOP);
  assign scope_idx     = scope_q;
  assign pass_pulse    = pass_q;
  assign respawn_pulse = resp_q;
  assign respawn_idx   = ridx_q;
endmodule

// File: tb/tb_obstacle_scroller.sv
// Bench for obstacle_scroller: a driver pushes the expected post-edge outputs
// into a queue; a negedge monitor pops and compares every cycle. The model
// tracks total distance scrolled and derives each edge with modular arithmetic.
module tb_obstacle_scroller;
  localparam int N = 5, XW = 10, PIPE_W = 61, COIN_W = 19, INTERVAL = 142;
  localparam int BIRD_X = 230, INIT_SCOPE = 2, IDX_W = $clog2(N), SPAN = N * INTERVAL;

  logic clk = 0, reset = 0, speed_tick = 0, start = 0, stop = 0, pause = 0, ack = 0;
  logic [2:0] step = 0;
  logic q_idle, q_run, q_pause, q_stop, pass_pulse, respawn_pulse;
  logic [IDX_W-1:0] scope_idx, respawn_idx;
  logic [N*XW-1:0] pipe_l, pipe_r, coin_l, coin_r;

  obstacle_scroller dut (
    .clk(clk), .reset(reset), .speed_tick(speed_tick), .step(step), .start(start),
    .stop(stop), .pause(pause), .ack(ack), .q_idle(q_idle), .q_run(q_run),
    .q_pause(q_pause), .q_stop(q_stop), .scope_idx(scope_idx), .pipe_l(pipe_l),
    .pipe_r(pipe_r), .coin_l(coin_l), .coin_r(coin_r), .pass_pulse(pass_pulse),
    .respawn_pulse(respawn_pulse), .respawn_idx(respawn_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] st;
    int scope, ridx;
    logic pass, resp;
    logic [N*XW-1:0] pr, pl, cl;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int n_chk = 0, n_fail = 0;

  // model: state 0 idle, 1 run, 2 pause, 3 stop; m_d = distance scrolled mod SPAN
  int m_st = 0, m_d = 0, m_scope = INIT_SCOPE, m_ridx = 0;
  logic m_pass = 0, m_resp = 0;

  function automatic int r_of(int i);
    return ((PIPE_W + i * INTERVAL - 1 - m_d) % SPAN + SPAN) % SPAN + 1;
  endfunction

  function automatic logic [XW-1:0] lane(logic [N*XW-1:0] v, int k);
    return v[k*XW +: XW];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst, tk, input int sp, input logic sta, sto, pa, ak);
    if (!rst) begin
      m_st = 0; m_d = 0; m_scope = INIT_SCOPE; m_pass = 0; m_resp = 0; m_ridx = 0;
      return;
    end
    m_pass = 0; m_resp = 0;
    if (m_st == 1 && tk && !sto && !pa && sp != 0) begin
      if (r_of(m_scope) < BIRD_X) begin m_scope = (m_scope + 1) % N; m_pass = 1; end
      for (int i = 0; i < N; i++) if (r_of(i) <= sp) begin m_resp = 1; m_ridx = i; end
      m_d = (m_d + sp) % SPAN;
    end
    case (m_st)
      0: if (sta) m_st = 1;
      1: if (sto) m_st = 3; else if (pa) m_st = 2;
      2: if (sto) m_st = 3; else if (!pa) m_st = 1;
      default: if (ak) m_st = 0;
    endcase
    if (m_st == 0) begin m_d = 0; m_scope = INIT_SCOPE; m_ridx = 0; end
  endtask

  function automatic exp_t expect_now();
    exp_t x;
    x.st = 4'b0001 << m_st;
    x.scope = m_scope; x.ridx = m_ridx; x.pass = m_pass; x.resp = m_resp;
    for (int k = 0; k < N; k++) begin
      int r = r_of((m_scope + k) % N);
      x.pr[k*XW +: XW] = XW'(r);
      x.pl[k*XW +: XW] = (r >= PIPE_W) ? XW'(r - PIPE_W) : '0;
      x.cl[k*XW +: XW] = (r >= COIN_W) ? XW'(r - COIN_W) : '0;
    end
    return x;
  endfunction

  task automatic drive(input logic rst, tk, input int sp, input logic sta, sto, pa, ak);
    @(negedge clk); #1;
    reset = rst; speed_tick = tk; step = sp[2:0]; start = sta; stop = sto; pause = pa; ack = ak;
    model_step(rst, tk, sp, sta, sto, pa, ak);
    q.push_back(expect_now());
  endtask

  task automatic tick(input int sp);
    drive(1, 1, sp, 0, 0, 0, 0);
    if ($urandom_range(0, 1) == 1) drive(1, 0, $urandom_range(0, 7), 0, 0, 0, 0);
  endtask

  task automatic settle();
    @(posedge clk); #2;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("state", {q_stop, q_pause, q_run, q_idle}, e.st);
      chk("scope_idx", scope_idx, e.scope);
      chk("pass_pulse", pass_pulse, e.pass);
      chk("respawn_pulse", respawn_pulse, e.resp);
      chk("respawn_idx", respawn_idx, e.ridx);
      chk("pipe_r", pipe_r, e.pr);
      chk("pipe_l", pipe_l, e.pl);
      chk("coin_r", coin_r, e.pr);
      chk("coin_l", coin_l, e.cl);
    end
  end

  initial begin
    int guard;
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    settle();
    chk("rst_idle", q_idle, 1);
    chk("rst_scope", scope_idx, 2);
    chk("rst_lane0_r", lane(pipe_r, 0), 345);

    drive(1, 0, 0, 1, 0, 0, 0);            // start
    drive(1, 1, 1, 0, 0, 0, 0);            // tick 1
    settle();
    chk("t1_lane0_r", lane(pipe_r, 0), 344);
    chk("t1_lane0_l", lane(pipe_l, 0), 283);
    chk("t1_slot0_r", lane(pipe_r, 3), 60);
    for (int i = 0; i < 59; i++) tick(1);  // 60 ticks
    settle();
    chk("t60_slot0_r", lane(pipe_r, 3), 1);
    chk("t60_slot0_l_clamp", lane(pipe_l, 3), 0);
    chk("t60_slot0_coin_l", lane(coin_l, 3), 0);
    drive(1, 1, 1, 0, 0, 0, 0);            // tick 61: slot 0 wraps
    settle();
    chk("wrap_slot0_r", lane(pipe_r, 3), 710);
    chk("wrap_pulse", respawn_pulse, 1);
    chk("wrap_idx", respawn_idx, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    settle();
    chk("wrap_pulse_clr", respawn_pulse, 0);
    for (int i = 0; i < 55; i++) tick(1);  // 116 ticks
    settle();
    chk("t116_lane0_r", lane(pipe_r, 0), 229);
    chk("t116_scope", scope_idx, 2);
    drive(1, 1, 1, 0, 0, 0, 0);            // tick 117: scope advance
    settle();
    chk("adv_scope", scope_idx, 3);
    chk("adv_pass", pass_pulse, 1);
    chk("adv_lane0_r", lane(pipe_r, 0), 370);
    drive(1, 0, 0, 0, 0, 0, 0);
    settle();
    chk("adv_pass_clr", pass_pulse, 0);

    for (int i = 0; i < 10; i++) drive(1, 1, 5, 0, 0, 1, 0);  // paused ticks
    settle();
    chk("pause_state", q_pause, 1);
    chk("pause_hold", lane(pipe_r, 0), 370);
    drive(1, 0, 0, 0, 0, 0, 0);            // back to RUN
    drive(1, 1, 3, 0, 1, 0, 0);            // stop with a tick
    settle();
    chk("stop_state", q_stop, 1);
    chk("stop_hold", lane(pipe_r, 0), 370);
    drive(1, 1, 3, 0, 0, 0, 1);            // ack
    settle();
    chk("ack_idle", q_idle, 1);
    chk("ack_scope", scope_idx, 2);
    chk("ack_lane0_r", lane(pipe_r, 0), 345);

    drive(1, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) tick(7);   // R[0] = 5
    drive(1, 1, 7, 0, 0, 0, 0);
    settle();
    chk("s7_slot0_r", lane(pipe_r, 3), 708);
    chk("s7_slot4_r", lane(pipe_r, 2), 566);
    chk("s7_resp", respawn_pulse, 1);
    chk("s7_resp_idx", respawn_idx, 0);

    for (int i = 0; i < 1500; i++)
      drive(1, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
            $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 2,
            $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 30);

    // get back to RUN from any state, then scroll until slot 4 is in scope
    drive(1, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 1, 0, 0, 0);
    guard = 0;
    while (m_scope != 4 && guard < 400) begin drive(1, 1, 7, 0, 0, 0, 0); guard++; end
    chk("reach_scope4_bound", guard < 400, 1);
    settle();
    chk("pre_rst_scope", scope_idx, 4);
    @(negedge clk); #2;
    reset = 0;
    model_step(0, 0, 0, 0, 0, 0, 0);
    q.push_back(expect_now());
    #1;
    chk("async_rst_idle", q_idle, 1);
    chk("async_rst_scope", scope_idx, 2);
    chk("async_rst_pass", pass_pulse, 0);
    chk("async_rst_resp", respawn_pulse, 0);
    chk("async_rst_lane0_r", lane(pipe_r, 0), 345);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
